// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// multi-cycle latency and raises Busy while an operation is in flight.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Op,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] C_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] C_DIV  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [3:0] OP_MTHI = 4'd6;
    localparam logic [3:0] OP_MTLO = 4'd7;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [1:0]    r_op;
    logic [31:0]   r_a, r_b, r_hi, r_lo;
    logic [31:0]   w_hi_nx, w_lo_nx;
    logic          w_latch;

    // Low 64 bits of a 64x64 product are sign-agnostic, so extension picks mult vs multu.
    logic [63:0] w_ax_s, w_bx_s, w_prod_s, w_prod_u;
    assign w_ax_s   = {{32{r_a[31]}}, r_a};
    assign w_bx_s   = {{32{r_b[31]}}, r_b};
    assign w_prod_s = w_ax_s * w_bx_s;
    assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;
    logic        w_div0;
    assign w_div0  = (r_b == 32'd0);
    assign w_a_mag = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_b_mag = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_q_mag = w_div0 ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = w_div0 ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_q_s   = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s   = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_q_u   = w_div0 ? 32'd0 : (r_a / r_b);
    assign w_r_u   = w_div0 ? 32'd0 : (r_a % r_b);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_latch    = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start && (Op[3:2] == 2'b00)) begin
                    w_latch    = 1'b1;
                    w_state_nx = RUN;
                    w_cnt_nx   = Op[1] ? C_DIV : C_MULT;
                end else if (!Start && (Op == OP_MTHI)) begin
                    w_hi_nx = A;
                end else if (!Start && (Op == OP_MTLO)) begin
                    w_lo_nx = A;
                end
            end
            RUN: begin
                if (r_cnt == C_ONE) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    case (r_op)
                        2'd0: {w_hi_nx, w_lo_nx} = w_prod_s;
                        2'd1: {w_hi_nx, w_lo_nx} = w_prod_u;
                        2'd2: if (!w_div0) begin w_hi_nx = w_r_s; w_lo_nx = w_q_s; end
                        default: if (!w_div0) begin w_hi_nx = w_r_u; w_lo_nx = w_q_u; end
                    endcase
                end else begin
                    w_cnt_nx = r_cnt - C_ONE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            if (w_latch) begin
                r_op <= Op[1:0];
                r_a  <= A;
                r_b  <= B;
            end
        end
    end

    assign Busy = (r_state == RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;
endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO/latency pushed at Start,
// popped and compared when Busy falls.
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Op;
    logic        Start;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Start(Start), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model, written independently of the RTL datapath.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0: begin q = sa * sb; p = q; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb; p = q; m_lo = p[31:0]; p = r; m_hi = p[31:0];
            end
            4'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            default: ;
        endcase
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
        exp_t e;
        int   n;
        model(op, a, b);
        e.tag = tag; e.hi = m_hi; e.lo = m_lo; e.cyc = (op >= 4'd2) ? DC : MC;
        sb.push_back(e);
        Op = op; A = a; B = b; Start = 1'b1;
        tick();
        chk({tag, "_busy_t0"}, 64'(Busy), 64'd1);
        n = 1;
        while (Busy && n < 200) begin
            A = $urandom; B = $urandom;
            Start = 1'b0; Op = 4'd15;
            if (disturb && n == 2) Op = 4'd6;
            if (disturb && n == 3) begin Op = 4'd2; Start = 1'b1; end
            tick();
            if (Busy) n++;
        end
        Op = 4'd15; Start = 1'b0;
        e = sb.pop_front();
        chk({e.tag, "_busy_cycles"}, 64'(n), 64'(e.cyc));
        chk({e.tag, "_hi"}, 64'(HI), 64'(e.hi));
        chk({e.tag, "_lo"}, 64'(LO), 64'(e.lo));
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        Op = op; A = a; Start = 1'b0;
        tick();
        Op = 4'd15;
        if (op == 4'd6) m_hi = a;
        if (op == 4'd7) m_lo = a;
    endtask

    initial begin
        reset = 1'b1; Op = 4'd15; Start = 1'b0; A = 0; B = 0;
        repeat (3) tick();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        reset = 1'b0;
        tick();

        mt(4'd7, 32'hCAFEF00D);
        chk("mtlo_lo", 64'(LO), 64'(m_lo));
        mt(4'd6, 32'h0BADBEEF);
        chk("mthi_hi", 64'(HI), 64'(m_hi));
        chk("mthi_busy", 64'(Busy), 64'd0);
        mt(4'd4, 32'h11111111);
        mt(4'd5, 32'h22222222);
        chk("mfhi_hi", 64'(HI), 64'h0BADBEEF);
        chk("mflo_lo", 64'(LO), 64'hCAFEF00D);

        issue("mult_neg3x5", 4'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        chk("mult_hi_const", 64'(HI), 64'hFFFFFFFF);
        chk("mult_lo_const", 64'(LO), 64'hFFFFFFF1);
        issue("multu_ffx2", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("multu_hi_const", 64'(HI), 64'h1);
        issue("div_neg7_2", 4'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_lo_const", 64'(LO), 64'hFFFFFFFD);
        chk("div_hi_const", 64'(HI), 64'hFFFFFFFF);
        issue("divu_7_2", 4'd3, 32'd7, 32'd2, 1'b0);
        issue("div_ovf", 4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div_ovf_lo_const", 64'(LO), 64'h80000000);
        issue("div_7_neg2", 4'd2, 32'd7, 32'hFFFFFFFE, 1'b0);

        mt(4'd6, 32'h12345678);
        mt(4'd7, 32'h0);
        issue("divu_by0", 4'd3, 32'd7, 32'd0, 1'b0);
        chk("divu_by0_hi_const", 64'(HI), 64'h12345678);
        issue("div_by0", 4'd2, 32'hFFFFFF00, 32'd0, 1'b0);

        for (int i = 0; i < 6; i++)
            issue("rand", 4'(i % 4), $urandom, (i == 5) ? 32'd3 : $urandom, 1'b0);

        issue("mult_disturb", 4'd0, 32'd1000, 32'd77, 1'b1);
        chk("disturb_busy_after", 64'(Busy), 64'd0);

        Op = 4'd5; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 4'd15;
        chk("start_badop_busy", 64'(Busy), 64'd0);
        chk("start_badop_lo", 64'(LO), 64'(m_lo));

        // Reset mid-division: must clear immediately and never deliver the result.
        Op = 4'd2; A = 32'd100; B = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 4'd15;
        repeat (3) tick();
        chk("midrst_busy_pre", 64'(Busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_hi", 64'(HI), 64'd0);
        chk("midrst_lo", 64'(LO), 64'd0);
        m_hi = 0; m_lo = 0;
        tick();
        reset = 1'b0;
        repeat (DC + 4) tick();
        chk("postrst_busy", 64'(Busy), 64'd0);
        chk("postrst_hi", 64'(HI), 64'd0);
        chk("postrst_lo", 64'(LO), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It is driven by the Op/Start decode from the E-stage controller. It owns the HI/LO architectural registers and feeds them back to the controller's E_HI/E_LO inputs for mfhi/mflo write-back. It models a fixed multi-cycle latency and exposes Busy, which the hazard unit uses to stall md-class instructions held in D.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu
DIV_CYCLES, 10, cycles Busy stays high for div/divu

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
Op  input  4  0=mult 1=multu 2=div 3=divu 4=mfhi 5=mflo 6=mthi 7=mtlo 15=nop; other codes treated as nop
Start  input  1  high for one cycle when a mult/multu/div/divu is in E
A  input  32  forwarded rs value (multiplicand / dividend / mthi-mtlo source)
B  input  32  forwarded rt value (multiplier / divisor)
Busy  output  1  registered; high while an operation is in flight
HI  output  32  registered HI
LO  output  32  registered LO

Behaviour:
- Reset (async, reset=1): HI=0, LO=0, Busy=0, counter=0, state=IDLE. Takes effect immediately, independent of clk.
- Reset mid-operation: the in-flight result is discarded; HI/LO hold 0 after reset releases.
- FSM states:
  - IDLE: Busy=0.
  - RUN: Busy=1; the down-counter decrements every edge.
- IDLE with Start=1 and Op in 0..3, at edge t0:
  - latch Op, A, B;
  - counter = MULT_CYCLES (Op 0/1) or DIV_CYCLES (Op 2/3);
  - state goes to RUN, so Busy=1 after t0.
- RUN with counter=1, at the next edge:
  - HI/LO get the result;
  - state goes to IDLE, Busy=0, counter=0.
- Net timing: Busy is high for exactly N cycles. New HI/LO are visible the cycle Busy falls.
- Start with Op not in 0..3 is ignored.
- Start while Busy=1 is ignored; the hazard unit guarantees this does not occur.
- mthi (Op=6) in IDLE with Start=0: HI=A at the edge. mtlo (Op=7): LO=A. Single-cycle, Busy stays 0.
- mthi/mtlo while Busy=1 are ignored. The stall condition (Start|Busy) in D prevents this.
- mfhi/mflo (Op 4/5) do not modify state. The controller reads the HI/LO outputs combinationally.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divisor=0 (div/divu): full DIV_CYCLES Busy, then HI/LO left unchanged.
- Results are computed from the operands latched at t0. A/B changes during RUN have no effect.
- Hazard unit contract (informational): stall D when an md-class instruction is in D and (Start|Busy)=1.

Test Plan:
- mult A=0xFFFFFFFD(-3), B=5, Start pulse -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9(-7), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then divu A=7, B=0 -> HI stays 0x12345678 and LO stays 0 after 10 Busy cycles.
- Start mult, then drive Op=6 and a second Start during Busy -> both ignored; only the mult result lands.
- Start div, assert reset at cycle 4 (between edges) -> HI=LO=0 and Busy=0 immediately. After release, no result write occurs.
